// File: rtl/snow_fb_sched_pkg.sv
// Shared types and default sizes for the snow framebuffer scheduler.
package snow_pkg;

    localparam int LAYERS_DEF = 3;
    localparam int ADDRW_DEF  = 16;

    typedef enum logic {S_IDLE, S_SWEEP} sched_state_t;

    typedef logic [LAYERS_DEF-1:0] layer_mask_t;

endpackage

// File: rtl/snow_fb_sched_if.sv
// Display/LFSR/RAM-facing signal bundle of snow_fb_sched.
// Optional statistics outputs appear when SNOW_FB_SCHED_STATS_EN is defined.
interface snow_fb_sched_if
    import snow_pkg::*;
#(
    parameter int ADDRW  = ADDRW_DEF,
    parameter int LAYERS = LAYERS_DEF
);
    logic              frame_start;
    logic              disp_req;
    logic [ADDRW-1:0]  disp_addr;
    logic [LAYERS-1:0] snow_bit;
    logic [LAYERS-1:0] lfsr_step;
    logic [ADDRW-1:0]  mem_addr;
    logic              mem_we;
    logic [LAYERS-1:0] mem_wmask;
    logic [LAYERS-1:0] mem_wdata;
    logic              busy;
    logic              overrun;
`ifdef SNOW_FB_SCHED_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       sweeps_done;

    modport master (
        output frame_start, disp_req, disp_addr, snow_bit,
        input  lfsr_step, mem_addr, mem_we, mem_wmask, mem_wdata, busy, overrun,
        input  stall_cnt, sweeps_done
    );
    modport slave (
        input  frame_start, disp_req, disp_addr, snow_bit,
        output lfsr_step, mem_addr, mem_we, mem_wmask, mem_wdata, busy, overrun,
        output stall_cnt, sweeps_done
    );
`else
    modport master (
        output frame_start, disp_req, disp_addr, snow_bit,
        input  lfsr_step, mem_addr, mem_we, mem_wmask, mem_wdata, busy, overrun
    );
    modport slave (
        input  frame_start, disp_req, disp_addr, snow_bit,
        output lfsr_step, mem_addr, mem_we, mem_wmask, mem_wdata, busy, overrun
    );
`endif
endinterface

// File: rtl/snow_fb_sched_frame_div.sv
// Frame counter and due-layer generator: layer L is due on frames where
// counter bit L rises, i.e. every 2**(L+1) frames.
module snow_frame_div
    import snow_pkg::*;
#(
    parameter int LAYERS = LAYERS_DEF
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              frame_start,
    output logic [LAYERS-1:0] due
);

    logic [LAYERS-1:0] fcnt_q;
    logic [LAYERS-1:0] fcnt_d;

    assign fcnt_d = fcnt_q + LAYERS'(1);
    assign due    = frame_start ? (fcnt_d & ~fcnt_q) : '0;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            fcnt_q <= '0;
        end else if (frame_start) begin
            fcnt_q <= fcnt_d;
        end
    end

endmodule

// File: rtl/snow_fb_sched.sv
// Shares the snow framebuffer port between display scan-out and the per-layer
// refresh sweep. Optional counters enabled by SNOW_FB_SCHED_STATS_EN.
module snow_fb_sched
    import snow_pkg::*;
#(
    parameter int ADDRW  = ADDRW_DEF,
    parameter int LAYERS = LAYERS_DEF
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    snow_fb_sched_if.slave bus
);

    localparam logic [ADDRW-1:0] ADDR_LAST = {ADDRW{1'b1}};

    sched_state_t      state_q, state_d;
    logic [ADDRW-1:0]  addr_q, addr_d;
    logic [LAYERS-1:0] cur_mask_q, cur_mask_d;
    logic [LAYERS-1:0] pend_mask_q, pend_mask_d;
    logic [LAYERS-1:0] due;
    logic [LAYERS-1:0] pend_acc;
    logic              grant;
    logic              last_grant;

    snow_frame_div #(.LAYERS(LAYERS)) u_frame_div (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .frame_start (bus.frame_start),
        .due         (due)
    );

    // Display owns the port whenever it asks; the sweep only writes in the gaps.
    assign grant      = (state_q == S_SWEEP) && !bus.disp_req && !rst_pix;
    assign last_grant = grant && (addr_q == ADDR_LAST);
    assign pend_acc   = pend_mask_q | due;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cur_mask_d  = cur_mask_q;
        pend_mask_d = pend_mask_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start && (due != '0)) begin
                    state_d    = S_SWEEP;
                    cur_mask_d = due;
                    addr_d     = '0;
                end
            end
            S_SWEEP: begin
                pend_mask_d = pend_acc;
                if (last_grant) begin
                    addr_d = '0;
                    if (pend_acc == '0) begin
                        state_d    = S_IDLE;
                        cur_mask_d = '0;
                    end else begin
                        cur_mask_d  = pend_acc;
                        pend_mask_d = '0;
                    end
                end else if (grant) begin
                    addr_d = addr_q + ADDRW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cur_mask_q  <= '0;
            pend_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cur_mask_q  <= cur_mask_d;
            pend_mask_q <= pend_mask_d;
        end
    end

    assign bus.busy      = (state_q == S_SWEEP);
    assign bus.overrun   = bus.frame_start && (state_q == S_SWEEP) && !rst_pix;
    assign bus.mem_we    = grant;
    assign bus.mem_wmask = grant ? cur_mask_q : '0;
    assign bus.mem_wdata = grant ? (bus.snow_bit & cur_mask_q) : '0;
    assign bus.lfsr_step = grant ? cur_mask_q : '0;
    assign bus.mem_addr  = bus.disp_req ? bus.disp_addr : (grant ? addr_q : '0);

`ifdef SNOW_FB_SCHED_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] sweeps_done_q;
    logic        sweep_start;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A restart after the last grant counts as a new sweep start.
    assign sweep_start = ((state_q == S_IDLE) && bus.frame_start && (due != '0))
                       || (last_grant && (pend_acc != '0));

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            stall_cnt_q   <= '0;
            sweeps_done_q <= '0;
        end else begin
            if (sweep_start) begin
                stall_cnt_q <= '0;
            end else if ((state_q == S_SWEEP) && bus.disp_req) begin
                stall_cnt_q <= sat_inc16(stall_cnt_q);
            end
            if (last_grant) begin
                sweeps_done_q <= sweeps_done_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.sweeps_done = sweeps_done_q;
`endif

endmodule
